// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel stream controller.
//  - Default image geometry (overridable per instance).
//  - Counter widths for column (line-buffer address), row and flush count.
//  - Sequencer state encoding.
//  - grey3(): luma-ish grey from R,G,B bytes: (R + 2G + B) >> 2 on a 10-bit sum, truncating.
package sobel_pkg;

  localparam int unsigned DefImgW   = 637;
  localparam int unsigned DefImgH   = 480;
  localparam int unsigned ColW      = 10;
  localparam int unsigned RowW      = 9;
  localparam int unsigned FlushCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  function automatic logic [7:0] grey3(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// Byte-stream input and datapath-control outputs of the Sobel stream controller.
//  master : byte source / observer (drives datain, data; sees everything else)
//  slave  : the controller (sees datain, data; drives everything else)
//  datain     byte strobe, every level change is one byte
//  data       byte value
//  pix_stb    pixel valid pulse (line-buffer write + window shift)
//  pix_data   grey pixel
//  lb_addr    column of current pixel
//  lb_rot     rotate line buffers (last pixel of a row)
//  win_valid  full 3x3 window available with this pixel
//  res_stb    datapath result valid
//  res_zero   result is a border fill
//  dataout    toggles on every res_stb
//  frame_done end-of-frame pulse
//  busy       sequencer not idle
interface sobel_stream_ctrl_if;
  import sobel_pkg::*;

  logic            datain;
  logic [7:0]      data;
  logic            pix_stb;
  logic [7:0]      pix_data;
  logic [ColW-1:0] lb_addr;
  logic            lb_rot;
  logic            win_valid;
  logic            res_stb;
  logic            res_zero;
  logic            dataout;
  logic            frame_done;
  logic            busy;

  modport master (
    output datain, data,
    input  pix_stb, pix_data, lb_addr, lb_rot, win_valid, res_stb, res_zero, dataout,
           frame_done, busy
  );

  modport slave (
    input  datain, data,
    output pix_stb, pix_data, lb_addr, lb_rot, win_valid, res_stb, res_zero, dataout,
           frame_done, busy
  );
endinterface

// File: rtl/sobel_stb_delay.sv
// Result-strobe delay line: shifts {stb, zero} through Lat stages so the strobe lines up
// with the datapath result. Also owns the DATAOUT toggle, which flips in the same cycle
// res_stb_o rises.
//  clk, rst_n   clock, async active-low reset (all stages cleared)
//  stb_i        strobe entering the line
//  zero_i       border-fill flag travelling with stb_i
//  res_stb_o    strobe after Lat cycles
//  res_zero_o   flag after Lat cycles
//  dataout_o    toggle output
module sobel_stb_delay #(
  parameter int unsigned Lat = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb_i,
  input  logic zero_i,
  output logic res_stb_o,
  output logic res_zero_o,
  output logic dataout_o
);

  logic [Lat-1:0] stb_q, stb_d;
  logic [Lat-1:0] zero_q, zero_d;
  logic           tgl_q, tgl_d;

  always_comb begin
    stb_d     = '0;
    zero_d    = '0;
    stb_d[0]  = stb_i;
    zero_d[0] = zero_i;
    for (int unsigned i = 1; i < Lat; i++) begin
      stb_d[i]  = stb_q[i-1];
      zero_d[i] = zero_q[i-1];
    end
    // Toggle with the strobe entering the last stage so both appear together.
    tgl_d = tgl_q ^ stb_d[Lat-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= '0;
      zero_q <= '0;
      tgl_q  <= 1'b0;
    end else begin
      stb_q  <= stb_d;
      zero_q <= zero_d;
      tgl_q  <= tgl_d;
    end
  end

  assign res_stb_o  = stb_q[Lat-1];
  assign res_zero_o = zero_q[Lat-1];
  assign dataout_o  = tgl_q;

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Sequencer between a toggle-strobed byte stream and the Sobel 3x3 window datapath.
// Packs BPP bytes (R,G,B) into a grey pixel, tracks column/row, drives line-buffer write,
// rotate and window-valid, and re-times the result strobe by SOBEL_LAT cycles.
//  clk, rst_n  clock, async active-low reset (discards any partial frame)
//  strm        sobel_stream_ctrl_if.slave (byte input, control/result outputs)
// Build option: BORDER_FILL_EN -- every pixel produces a result strobe; border pixels
//  (row<2 or col<2) flag res_zero. Without it only full-window pixels produce results.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W     = DefImgW,
  parameter int unsigned IMG_H     = DefImgH,
  parameter int unsigned BPP       = 3,
  parameter int unsigned SOBEL_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  sobel_stream_ctrl_if.slave strm
);

  localparam logic [1:0]           PhLast    = 2'(BPP - 1);
  localparam logic [ColW-1:0]      ColLast   = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0]      RowLast   = RowW'(IMG_H - 1);
  localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(SOBEL_LAT - 1);

  state_e               state_q, state_d;
  logic                 din_q;
  logic [1:0]           ph_q, ph_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [7:0]           byte0_q, byte0_d;
  logic [7:0]           byte1_q, byte1_d;
  logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;

  logic                 pix_stb_q, pix_stb_d;
  logic [7:0]           pix_data_q, pix_data_d;
  logic [ColW-1:0]      lb_addr_q, lb_addr_d;
  logic                 lb_rot_q, lb_rot_d;
  logic                 win_valid_q, win_valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic byte_ev, accept, pix_done, col_end, last_pix;
  logic dly_stb, dly_zero;

  assign byte_ev  = strm.datain ^ din_q;
  // Bytes are only taken while idle (frame start) or running; flush/done drop them.
  assign accept   = byte_ev && ((state_q == StIdle) || (state_q == StRun));
  assign pix_done = accept && (ph_q == PhLast);
  assign col_end  = (col_q == ColLast);
  assign last_pix = col_end && (row_q == RowLast);

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    col_d        = col_q;
    row_d        = row_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    flush_cnt_d  = flush_cnt_q;
    pix_data_d   = pix_data_q;
    lb_addr_d    = lb_addr_q;
    pix_stb_d    = pix_done;
    // No rotate on the frame's final pixel: nothing follows it in this frame.
    lb_rot_d     = pix_done && col_end && !last_pix;
    win_valid_d  = pix_done && (row_q >= RowW'(2)) && (col_q >= ColW'(2));

    if (accept) begin
      ph_d = (ph_q == PhLast) ? 2'd0 : ph_q + 2'd1;
      if (ph_q == 2'd0) byte0_d = strm.data;
      if (ph_q == 2'd1) byte1_d = strm.data;
    end

    if (pix_done) begin
      pix_data_d = (BPP == 1) ? strm.data : grey3(byte0_q, byte1_q, strm.data);
      lb_addr_d  = col_q;
      if (col_end) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        flush_cnt_d = '0;
        if (accept) state_d = (pix_done && last_pix) ? StFlush : StRun;
      end
      StRun: begin
        flush_cnt_d = '0;
        if (pix_done && last_pix) state_d = StFlush;
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) state_d = StDone;
        else flush_cnt_d = flush_cnt_q + FlushCntW'(1);
      end
      StDone: begin
        state_d = StIdle;
        ph_d    = '0;
        col_d   = '0;
        row_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      din_q        <= 1'b0;
      ph_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      byte0_q      <= '0;
      byte1_q      <= '0;
      flush_cnt_q  <= '0;
      pix_stb_q    <= 1'b0;
      pix_data_q   <= '0;
      lb_addr_q    <= '0;
      lb_rot_q     <= 1'b0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= strm.datain;
      ph_q         <= ph_d;
      col_q        <= col_d;
      row_q        <= row_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      flush_cnt_q  <= flush_cnt_d;
      pix_stb_q    <= pix_stb_d;
      pix_data_q   <= pix_data_d;
      lb_addr_q    <= lb_addr_d;
      lb_rot_q     <= lb_rot_d;
      win_valid_q  <= win_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BORDER_FILL_EN
  assign dly_stb  = pix_stb_q;
  assign dly_zero = pix_stb_q & ~win_valid_q;
`else
  assign dly_stb  = win_valid_q;
  assign dly_zero = 1'b0;
`endif

  sobel_stb_delay #(
    .Lat (SOBEL_LAT)
  ) u_stb_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .stb_i      (dly_stb),
    .zero_i     (dly_zero),
    .res_stb_o  (strm.res_stb),
    .res_zero_o (strm.res_zero),
    .dataout_o  (strm.dataout)
  );

  assign strm.pix_stb    = pix_stb_q;
  assign strm.pix_data   = pix_data_q;
  assign strm.lb_addr    = lb_addr_q;
  assign strm.lb_rot     = lb_rot_q;
  assign strm.win_valid  = win_valid_q;
  assign strm.busy       = busy_q;
  assign strm.frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Scoreboard bench for sobel_stream_ctrl with a 4x3 image, 3 bytes/pixel, latency 2.
module tb_sobel_stream_ctrl;
  import sobel_pkg::*;

  localparam int unsigned ImgW = 4;
  localparam int unsigned ImgH = 3;
  localparam int unsigned Bpp  = 3;
  localparam int unsigned Lat  = 2;
  localparam int unsigned NPix = ImgW * ImgH;
`ifdef BORDER_FILL_EN
  localparam int unsigned ExpRes  = NPix;
  localparam int unsigned ExpZero = NPix - (ImgW - 2) * (ImgH - 2);
`else
  localparam int unsigned ExpRes  = (ImgW - 2) * (ImgH - 2);
  localparam int unsigned ExpZero = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  sobel_stream_ctrl_if strm ();

  sobel_stream_ctrl #(
    .IMG_W     (ImgW),
    .IMG_H     (ImgH),
    .BPP       (Bpp),
    .SOBEL_LAT (Lat)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .strm  (strm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic [9:0] addr;
    logic       rot;
    logic       win;
    logic       yields;
    logic       zero;
  } pix_exp_t;

  typedef struct {
    int unsigned due;
    logic        zero;
  } res_exp_t;

  pix_exp_t    pix_q[$];
  res_exp_t    res_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_pix, n_rot, n_res, n_zero, n_done;
  int unsigned exp_col, exp_row;
  logic        exp_dout = 1'b0;
  logic [25:0] outs;

  assign outs = {strm.pix_stb, strm.pix_data, strm.lb_addr, strm.lb_rot, strm.win_valid,
                 strm.res_stb, strm.res_zero, strm.dataout, strm.frame_done, strm.busy};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Output monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    pix_exp_t e;
    res_exp_t r;
    if (strm.pix_stb) begin
      n_pix++;
      if (strm.lb_rot) n_rot++;
      if (pix_q.size() == 0) begin
        check("pix_unexpected", 1, 0);
      end else begin
        e = pix_q.pop_front();
        check("pix_data", strm.pix_data, e.pix);
        check("lb_addr", strm.lb_addr, e.addr);
        check("lb_rot", strm.lb_rot, e.rot);
        check("win_valid", strm.win_valid, e.win);
        if (e.yields) begin
          r.due  = cyc + Lat;
          r.zero = e.zero;
          res_q.push_back(r);
        end
      end
    end else if (strm.lb_rot || strm.win_valid) begin
      check("strobe_without_pix", {strm.lb_rot, strm.win_valid}, 0);
    end
    if (strm.res_stb) begin
      n_res++;
      if (strm.res_zero) n_zero++;
      exp_dout = ~exp_dout;
      check("dataout_toggle", strm.dataout, exp_dout);
      if (res_q.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else begin
        r = res_q.pop_front();
        check("res_latency", cyc, r.due);
        check("res_zero", strm.res_zero, r.zero);
      end
    end else if (strm.res_zero) begin
      check("zero_without_stb", 1, 0);
    end
    if (strm.frame_done) n_done++;
  end

  task automatic new_frame();
    n_pix = 0; n_rot = 0; n_res = 0; n_zero = 0; n_done = 0;
    exp_col = 0; exp_row = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    strm.data   = b;
    strm.datain = ~strm.datain;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit rand_gap);
    pix_exp_t e;
    logic [9:0] sum;
    sum    = 10'(r) + 10'(g) + 10'(g) + 10'(b);
    e.pix  = sum[9:2];
    e.addr = 10'(exp_col);
    e.rot  = (exp_col == ImgW - 1) && (exp_row != ImgH - 1);
    e.win  = (exp_row >= 2) && (exp_col >= 2);
`ifdef BORDER_FILL_EN
    e.yields = 1'b1;
    e.zero   = !e.win;
`else
    e.yields = e.win;
    e.zero   = 1'b0;
`endif
    pix_q.push_back(e);
    if (exp_col == ImgW - 1) begin
      exp_col = 0;
      exp_row++;
    end else begin
      exp_col++;
    end
    send_byte(r, rand_gap ? $urandom_range(0, 2) : 0);
    send_byte(g, rand_gap ? $urandom_range(0, 2) : 0);
    send_byte(b, rand_gap ? $urandom_range(0, 2) : 0);
  endtask

  task automatic send_rand_pixel(input bit rand_gap);
    send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), rand_gap);
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 60 && n_done == 0; i++) @(negedge clk);
    check("frame_done_seen", n_done, 1);
    repeat (6) @(negedge clk);
    check("frame_done_once", n_done, 1);
    check("pix_count", n_pix, NPix);
    check("rot_count", n_rot, 2);
    check("res_count", n_res, ExpRes);
    check("zero_count", n_zero, ExpZero);
    check("dataout_end", strm.dataout, ExpRes % 2);
    check("busy_after", strm.busy, 0);
    check("pix_q_empty", pix_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
  endtask

  initial begin
    strm.datain = 1'b0;
    strm.data   = 8'h00;
    new_frame();

    // Reset held while the strobe toggles.
    repeat (4) begin
      @(posedge clk);
      #1;
      strm.datain = ~strm.datain;
      strm.data   = 8'hA5;
    end
    @(negedge clk);
    check("reset_outputs", outs, 0);
    check("reset_busy", strm.busy, 0);
    strm.datain = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame A: fixed first pixel, one back-to-back pixel, then a dropped flush-time byte.
    send_pixel(8'h10, 8'h20, 8'h30, 1'b0);
    repeat (3) @(negedge clk);
    check("first_pix_count", n_pix, 1);
    check("busy_running", strm.busy, 1);
    for (int p = 1; p < NPix; p++) begin
      if (p == 4) begin
        send_rand_pixel(1'b0);
        repeat (3) @(negedge clk);
        check("burst_one_pix", n_pix, 5);
      end else begin
        send_rand_pixel(1'b1);
      end
    end
    @(posedge clk);
    #1 strm.datain = ~strm.datain;
    finish_frame();

    // Frame B: reset after 7 pixels.
    new_frame();
    for (int p = 0; p < 7; p++) send_rand_pixel(1'b1);
    repeat (3) @(negedge clk);
    check("pre_reset_pix", n_pix, 7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    strm.datain = 1'b0;
    @(negedge clk);
    check("midreset_outputs", outs, 0);
    check("midreset_busy", strm.busy, 0);
    pix_q.delete();
    res_q.delete();
    exp_dout = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame C: full frame after the mid-frame reset.
    new_frame();
    for (int p = 0; p < NPix; p++) send_rand_pixel(1'b1);
    finish_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
